// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with complementary outputs and word-framing counter
module univ_shift_reg #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    parameter int                 CNT_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] pin,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] qout,
    output logic [WIDTH-1:0] qbar,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             word_done
);

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_SHR   = 3'b011;
    localparam logic [2:0] MODE_ROTL  = 3'b100;
    localparam logic [2:0] MODE_ROTR  = 3'b101;
    localparam logic [2:0] MODE_ASR   = 3'b110;
    localparam logic [2:0] MODE_CLEAR = 3'b111;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] qout_q, qout_d;
    logic [WIDTH-1:0] qbar_q, qbar_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             is_shift;

    always_comb begin
        qout_d   = qout_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        is_shift = 1'b0;
        if (en) begin
            case (mode)
                MODE_HOLD:  qout_d = qout_q;
                MODE_LOAD:  begin qout_d = pin; cnt_d = '0; end
                MODE_SHL:   begin qout_d = {qout_q[WIDTH-2:0], sin_r};          is_shift = 1'b1; end
                MODE_SHR:   begin qout_d = {sin_l, qout_q[WIDTH-1:1]};          is_shift = 1'b1; end
                MODE_ROTL:  begin qout_d = {qout_q[WIDTH-2:0], qout_q[WIDTH-1]}; is_shift = 1'b1; end
                MODE_ROTR:  begin qout_d = {qout_q[0], qout_q[WIDTH-1:1]};      is_shift = 1'b1; end
                MODE_ASR:   begin qout_d = {qout_q[WIDTH-1], qout_q[WIDTH-1:1]}; is_shift = 1'b1; end
                MODE_CLEAR: begin qout_d = '0; cnt_d = '0; end
                default:    qout_d = qout_q;
            endcase
        end
        // Every shift class shares one counter; the wrap edge marks a full serial word.
        if (is_shift) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        qbar_d = ~qout_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            qout_q <= RESET_VAL;
            qbar_q <= ~RESET_VAL;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            qout_q <= qout_d;
            qbar_q <= qbar_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign qout      = qout_q;
    assign qbar      = qbar_q;
    assign sout_msb  = qout_q[WIDTH-1];
    assign sout_lsb  = qout_q[0];
    assign shift_cnt = cnt_q;
    assign word_done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - directed self-checking bench for univ_shift_reg
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, sin_r, sin_l;
    logic [2:0] mode;
    logic [7:0] pin, qout, qbar;
    logic       sout_msb, sout_lsb, word_done;
    logic [2:0] shift_cnt;

    logic       rst2, en2, sin_r2, sin_l2;
    logic [2:0] mode2;
    logic [1:0] pin2, qout2, qbar2;
    logic       sout_msb2, sout_lsb2, word_done2;
    logic [0:0] shift_cnt2;

    int n_cmp = 0;
    int n_err = 0;

    univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .pin(pin),
        .sin_r(sin_r), .sin_l(sin_l), .qout(qout), .qbar(qbar),
        .sout_msb(sout_msb), .sout_lsb(sout_lsb),
        .shift_cnt(shift_cnt), .word_done(word_done)
    );

    univ_shift_reg #(.WIDTH(2), .RESET_VAL(2'b00)) dut2 (
        .clk(clk), .rst(rst2), .en(en2), .mode(mode2), .pin(pin2),
        .sin_r(sin_r2), .sin_l(sin_l2), .qout(qout2), .qbar(qbar2),
        .sout_msb(sout_msb2), .sout_lsb(sout_lsb2),
        .shift_cnt(shift_cnt2), .word_done(word_done2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [2:0] m, input logic [7:0] p, input logic sr, input logic sl);
        en = 1'b1; mode = m; pin = p; sin_r = sr; sin_l = sl;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; mode = 3'b001; pin = 8'hFF;
        step();
        rst = 1'b0;
        n_cmp++; if (qout !== 8'hA5) begin n_err++; $display("FAIL reset_qout: got %h want a5", qout); end
        n_cmp++; if (qbar !== 8'h5A) begin n_err++; $display("FAIL reset_qbar: got %h want 5a", qbar); end
        n_cmp++; if (shift_cnt !== 3'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", shift_cnt); end
        n_cmp++; if (word_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", word_done); end
        n_cmp++; if (sout_msb !== 1'b1 || sout_lsb !== 1'b1) begin n_err++; $display("FAIL reset_sout: got %b%b want 11", sout_msb, sout_lsb); end
    endtask

    task automatic test_load_hold();
        op(3'b001, 8'h3C, 1'b0, 1'b0);
        n_cmp++; if (qout !== 8'h3C) begin n_err++; $display("FAIL load_qout: got %h want 3c", qout); end
        n_cmp++; if (qbar !== 8'hC3) begin n_err++; $display("FAIL load_qbar: got %h want c3", qbar); end
        en = 1'b0; mode = 3'b111;
        step(); step();
        n_cmp++; if (qout !== 8'h3C) begin n_err++; $display("FAIL en0_hold: got %h want 3c", qout); end
        op(3'b000, 8'h00, 1'b0, 1'b0);
        n_cmp++; if (qout !== 8'h3C) begin n_err++; $display("FAIL mode_hold: got %h want 3c", qout); end
    endtask

    task automatic test_sipo();
        logic [7:0] bits;
        bits = 8'b1011_0010;
        op(3'b111, 8'h00, 1'b0, 1'b0);
        n_cmp++; if (qout !== 8'h00 || qbar !== 8'hFF) begin n_err++; $display("FAIL clear: got %h/%h want 00/ff", qout, qbar); end
        for (int i = 0; i < 8; i++) begin
            op(3'b010, 8'h00, bits[7-i], 1'b0);
            if (i == 6) begin
                n_cmp++; if (word_done !== 1'b0 || shift_cnt !== 3'd7) begin n_err++; $display("FAIL sipo_7th: got done=%b cnt=%0d want 0/7", word_done, shift_cnt); end
            end
        end
        n_cmp++; if (qout !== 8'hB2) begin n_err++; $display("FAIL sipo_qout: got %h want b2", qout); end
        n_cmp++; if (word_done !== 1'b1 || shift_cnt !== 3'd0) begin n_err++; $display("FAIL sipo_done: got done=%b cnt=%0d want 1/0", word_done, shift_cnt); end
        op(3'b000, 8'h00, 1'b0, 1'b0);
        n_cmp++; if (word_done !== 1'b0) begin n_err++; $display("FAIL sipo_pulse_len: got %b want 0", word_done); end
    endtask

    task automatic test_rotate_asr();
        op(3'b001, 8'h81, 1'b0, 1'b0);
        op(3'b100, 8'h00, 1'b0, 1'b0);
        n_cmp++; if (qout !== 8'h03) begin n_err++; $display("FAIL rotl: got %h want 03", qout); end
        op(3'b101, 8'h00, 1'b0, 1'b0);
        n_cmp++; if (qout !== 8'h81) begin n_err++; $display("FAIL rotr: got %h want 81", qout); end
        op(3'b110, 8'h00, 1'b0, 1'b0);
        n_cmp++; if (qout !== 8'hC0) begin n_err++; $display("FAIL asr1: got %h want c0", qout); end
        op(3'b110, 8'h00, 1'b0, 1'b0);
        n_cmp++; if (qout !== 8'hE0 || qbar !== 8'h1F) begin n_err++; $display("FAIL asr2: got %h/%h want e0/1f", qout, qbar); end
        op(3'b011, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (qout !== 8'h70) begin n_err++; $display("FAIL shr: got %h want 70", qout); end
        n_cmp++; if (shift_cnt !== 3'd5) begin n_err++; $display("FAIL mixed_cnt: got %0d want 5", shift_cnt); end
    endtask

    task automatic test_count_reset();
        int pulses;
        op(3'b001, 8'h5A, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) op(3'b011, 8'h00, 1'b0, 1'b1);
        n_cmp++; if (shift_cnt !== 3'd5) begin n_err++; $display("FAIL cnt5: got %0d want 5", shift_cnt); end
        en = 1'b0; mode = 3'b011;
        step();
        n_cmp++; if (shift_cnt !== 3'd5 || qout !== 8'hFA) begin n_err++; $display("FAIL en0_cnt: got %0d/%h want 5/fa", shift_cnt, qout); end
        op(3'b001, 8'h5A, 1'b0, 1'b0);
        n_cmp++; if (shift_cnt !== 3'd0) begin n_err++; $display("FAIL load_cnt: got %0d want 0", shift_cnt); end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            op(3'b011, 8'h00, 1'b0, 1'b0);
            if (word_done === 1'b1) pulses++;
        end
        n_cmp++; if (pulses !== 1 || word_done !== 1'b1) begin n_err++; $display("FAIL one_pulse: got pulses=%0d done=%b want 1/1", pulses, word_done); end
        n_cmp++; if (qout !== 8'h00) begin n_err++; $display("FAIL shr8: got %h want 00", qout); end
    endtask

    task automatic test_mid_reset();
        op(3'b001, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) op(3'b010, 8'h00, 1'b0, 1'b0);
        n_cmp++; if (qout !== 8'hF0 || shift_cnt !== 3'd4) begin n_err++; $display("FAIL pre_rst: got %h/%0d want f0/4", qout, shift_cnt); end
        rst = 1'b1; mode = 3'b010;
        step();
        n_cmp++; if (qout !== 8'hA5 || shift_cnt !== 3'd0 || word_done !== 1'b0) begin n_err++; $display("FAIL mid_rst: got %h/%0d/%b want a5/0/0", qout, shift_cnt, word_done); end
        rst = 1'b0; en = 1'b0;
        step();
        n_cmp++; if (word_done !== 1'b0 || qout !== 8'hA5) begin n_err++; $display("FAIL post_rst: got %h/%b want a5/0", qout, word_done); end
    endtask

    task automatic test_width2();
        en2 = 1'b1; mode2 = 3'b001; pin2 = 2'b01;
        step();
        n_cmp++; if (qout2 !== 2'b01 || qbar2 !== 2'b10) begin n_err++; $display("FAIL w2_load: got %b/%b want 01/10", qout2, qbar2); end
        mode2 = 3'b100;
        step();
        n_cmp++; if (qout2 !== 2'b10 || shift_cnt2 !== 1'b1 || word_done2 !== 1'b0) begin n_err++; $display("FAIL w2_rot1: got %b/%b/%b want 10/1/0", qout2, shift_cnt2, word_done2); end
        step();
        n_cmp++; if (qout2 !== 2'b01 || shift_cnt2 !== 1'b0 || word_done2 !== 1'b1) begin n_err++; $display("FAIL w2_rot2: got %b/%b/%b want 01/0/1", qout2, shift_cnt2, word_done2); end
        en2 = 1'b0;
        step();
        n_cmp++; if (word_done2 !== 1'b0 || sout_lsb2 !== 1'b1 || sout_msb2 !== 1'b0) begin n_err++; $display("FAIL w2_after: got done=%b sout=%b%b want 0/01", word_done2, sout_msb2, sout_lsb2); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 3'b000; pin = 8'h00; sin_r = 1'b0; sin_l = 1'b0;
        rst2 = 1'b1; en2 = 1'b0; mode2 = 3'b000; pin2 = 2'b00; sin_r2 = 1'b0; sin_l2 = 1'b0;
        step();
        rst2 = 1'b0;
        test_reset();
        test_load_hold();
        test_sipo();
        test_rotate_asr();
        test_count_reset();
        test_mid_reset();
        test_width2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
